// File: rtl/nios_arb_pkg.sv
// Shared types and constants for the nios_2 unified-memory arbiter.
package nios_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_DM   = 2'd2
    } owner_t;

    localparam int MEM_LAT_MAX = 4;
    localparam int ADDR_W_DEF  = 32;
    localparam int DATA_W_DEF  = 32;

endpackage

// File: rtl/nios_mem_arbiter_if.sv
// Fetch, load/store and memory-macro signals seen by the arbiter.
// slave = arbiter side, master = core/memory side.
interface nios_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req_i;
    logic [ADDR_W-1:0] if_addr_i;
    logic              if_gnt_o;
    logic              if_rvalid_o;
    logic [DATA_W-1:0] if_rdata_o;

    logic              dm_req_i;
    logic              dm_we_i;
    logic [ADDR_W-1:0] dm_addr_i;
    logic [DATA_W-1:0] dm_wdata_i;
    logic              dm_gnt_o;
    logic              dm_rvalid_o;
    logic [DATA_W-1:0] dm_rdata_o;

    logic              mem_en_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic [DATA_W-1:0] mem_rdata_i;

    modport slave (
        input  if_req_i, if_addr_i, dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i, mem_rdata_i,
        output if_gnt_o, if_rvalid_o, if_rdata_o, dm_gnt_o, dm_rvalid_o, dm_rdata_o,
        output mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o
    );

    modport master (
        output if_req_i, if_addr_i, dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i, mem_rdata_i,
        input  if_gnt_o, if_rvalid_o, if_rdata_o, dm_gnt_o, dm_rvalid_o, dm_rdata_o,
        input  mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o
    );

endinterface

// File: rtl/nios_arb_tag_pipe.sv
// Fixed-depth owner-tag delay line matching the memory read latency.
module nios_arb_tag_pipe
    import nios_arb_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic   clk,
    input  logic   rst,
    input  owner_t tag_in,
    output owner_t tag_out
);

    owner_t stage [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= OWN_NONE;
        end else begin
            stage[0] <= tag_in;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    assign tag_out = stage[DEPTH-1];

endmodule

// File: rtl/nios_mem_arbiter.sv
// Single-port memory arbiter between nios_2 fetch and load/store ports.
// Define ARB_ROUND_ROBIN_EN for round-robin; default is data-over-fetch with starvation guard.
module nios_mem_arbiter
    import nios_arb_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 8
) (
    input logic               clk,
    input logic               rst,
    nios_mem_arbiter_if.slave bus
);

    logic              if_gnt;
    logic              dm_gnt;
    logic              win_we;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;
    owner_t            tag_in;
    owner_t            tag_out;

`ifdef ARB_ROUND_ROBIN_EN
    // Set means fetch gets the tie next; flips only on grant cycles.
    logic prefer_if;

    always_ff @(posedge clk) begin
        if (rst)         prefer_if <= 1'b1;
        else if (if_gnt) prefer_if <= 1'b0;
        else if (dm_gnt) prefer_if <= 1'b1;
    end

    always_comb begin
        if_gnt = 1'b0;
        dm_gnt = 1'b0;
        if (!rst) begin
            if (bus.if_req_i && (prefer_if || !bus.dm_req_i)) if_gnt = 1'b1;
            else if (bus.dm_req_i)                             dm_gnt = 1'b1;
        end
    end
`else
    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0] starve_cnt;
    logic             force_if;

    assign force_if = bus.if_req_i && (starve_cnt == CNT_W'(STARVE_MAX));

    always_ff @(posedge clk) begin
        if (rst)                                                  starve_cnt <= '0;
        else if (if_gnt)                                          starve_cnt <= '0;
        else if (bus.if_req_i && starve_cnt != CNT_W'(STARVE_MAX)) starve_cnt <= starve_cnt + 1'b1;
    end

    always_comb begin
        if_gnt = 1'b0;
        dm_gnt = 1'b0;
        if (!rst) begin
            if (force_if)          if_gnt = 1'b1;
            else if (bus.dm_req_i) dm_gnt = 1'b1;
            else if (bus.if_req_i) if_gnt = 1'b1;
        end
    end
`endif

    // Winner's payload onto the memory bus; stores never get a response tag.
    always_comb begin
        win_we    = 1'b0;
        win_addr  = '0;
        win_wdata = '0;
        tag_in    = OWN_NONE;
        if (if_gnt) begin
            win_addr = bus.if_addr_i;
            tag_in   = OWN_IF;
        end else if (dm_gnt) begin
            win_we    = bus.dm_we_i;
            win_addr  = bus.dm_addr_i;
            win_wdata = bus.dm_wdata_i;
            tag_in    = bus.dm_we_i ? OWN_NONE : OWN_DM;
        end
    end

    nios_arb_tag_pipe #(.DEPTH(MEM_LAT)) u_tag_pipe (
        .clk     (clk),
        .rst     (rst),
        .tag_in  (tag_in),
        .tag_out (tag_out)
    );

    assign bus.if_gnt_o    = if_gnt;
    assign bus.dm_gnt_o    = dm_gnt;
    assign bus.mem_en_o    = if_gnt | dm_gnt;
    assign bus.mem_we_o    = win_we;
    assign bus.mem_addr_o  = win_addr;
    assign bus.mem_wdata_o = win_wdata;

    assign bus.if_rvalid_o = !rst && (tag_out == OWN_IF);
    assign bus.dm_rvalid_o = !rst && (tag_out == OWN_DM);
    assign bus.if_rdata_o  = bus.mem_rdata_i;
    assign bus.dm_rdata_o  = bus.mem_rdata_i;

endmodule

// File: tb/tb_nios_mem_arbiter.sv
// Directed self-checking bench for nios_mem_arbiter (MEM_LAT=1 and MEM_LAT=3 instances).
// Honors ARB_ROUND_ROBIN_EN to select the matching expectations.
module tb_nios_mem_arbiter;

    typedef struct {
        string       name;
        logic        if_req;
        logic [31:0] if_addr;
        logic        dm_req;
        logic        dm_we;
        logic [31:0] dm_addr;
        logic [31:0] dm_wdata;
        logic        exp_if_gnt;
        logic        exp_dm_gnt;
        logic        exp_we;
        logic [31:0] exp_addr;
        logic [31:0] exp_wdata;
        logic        exp_if_rv;
        logic        exp_dm_rv;
        logic [31:0] exp_rdata;
    } vec_t;

    logic clk;
    logic rst;
    logic rst3;
    int   total = 0;
    int   bad   = 0;

    nios_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();
    nios_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus3 ();

    nios_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(8)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    nios_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3), .STARVE_MAX(8)) dut3 (
        .clk (clk),
        .rst (rst3),
        .bus (bus3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] memval(input logic [31:0] a);
        return (a == 32'h82) ? 32'h9 : (a ^ 32'h5A5A_0000);
    endfunction

    // Memory macro models: 1-cycle and 3-cycle read latency.
    logic [31:0] m1, d1, d2, d3;
    always @(posedge clk) begin
        m1 <= memval(bus1.mem_addr_o);
        d1 <= memval(bus3.mem_addr_o);
        d2 <= d1;
        d3 <= d2;
    end
    assign bus1.mem_rdata_i = m1;
    assign bus3.mem_rdata_i = d3;

    function automatic vec_t mk(input string n, input logic ir, input logic [31:0] ia,
                                input logic dr, input logic dw, input logic [31:0] da,
                                input logic [31:0] dd, input logic eig, input logic edg,
                                input logic ewe, input logic [31:0] ea, input logic [31:0] ewd,
                                input logic eir, input logic edr, input logic [31:0] erd);
        vec_t v;
        v.name = n; v.if_req = ir; v.if_addr = ia; v.dm_req = dr; v.dm_we = dw;
        v.dm_addr = da; v.dm_wdata = dd; v.exp_if_gnt = eig; v.exp_dm_gnt = edg;
        v.exp_we = ewe; v.exp_addr = ea; v.exp_wdata = ewd; v.exp_if_rv = eir;
        v.exp_dm_rv = edr; v.exp_rdata = erd;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        bus1.if_req_i   = v.if_req;
        bus1.if_addr_i  = v.if_addr;
        bus1.dm_req_i   = v.dm_req;
        bus1.dm_we_i    = v.dm_we;
        bus1.dm_addr_i  = v.dm_addr;
        bus1.dm_wdata_i = v.dm_wdata;
    endtask

    task automatic checkOutput(input vec_t v);
        #2;
        check({v.name, ".if_gnt"},    32'(bus1.if_gnt_o),    32'(v.exp_if_gnt));
        check({v.name, ".dm_gnt"},    32'(bus1.dm_gnt_o),    32'(v.exp_dm_gnt));
        check({v.name, ".mem_en"},    32'(bus1.mem_en_o),    32'(v.exp_if_gnt | v.exp_dm_gnt));
        check({v.name, ".mem_we"},    32'(bus1.mem_we_o),    32'(v.exp_we));
        check({v.name, ".mem_addr"},  bus1.mem_addr_o,       v.exp_addr);
        check({v.name, ".mem_wdata"}, bus1.mem_wdata_o,      v.exp_wdata);
        check({v.name, ".if_rvalid"}, 32'(bus1.if_rvalid_o), 32'(v.exp_if_rv));
        check({v.name, ".dm_rvalid"}, 32'(bus1.dm_rvalid_o), 32'(v.exp_dm_rv));
        if (v.exp_if_rv) check({v.name, ".if_rdata"}, bus1.if_rdata_o, v.exp_rdata);
        if (v.exp_dm_rv) check({v.name, ".dm_rdata"}, bus1.dm_rdata_o, v.exp_rdata);
    endtask

    task automatic drive3(input logic req, input logic [31:0] addr);
        @(negedge clk);
        bus3.dm_req_i  = req;
        bus3.dm_addr_i = addr;
    endtask

    vec_t tbl [8];
    vec_t v;

    initial begin
        tbl[0] = mk("idle",     0, 0,      0, 0, 0,     0,            0, 0, 0, 0,      0,            0, 0, 0);
        tbl[1] = mk("fetch",    1, 32'h100, 0, 0, 0,    0,            1, 0, 0, 32'h100, 0,           0, 0, 0);
        tbl[2] = mk("load82",   0, 0,      1, 0, 32'h82, 0,           0, 1, 0, 32'h82, 0,            1, 0, memval(32'h100));
        tbl[3] = mk("store",    0, 0,      1, 1, 32'h10, 32'hDEADBEEF, 0, 1, 1, 32'h10, 32'hDEADBEEF, 0, 1, 32'h9);
`ifdef ARB_ROUND_ROBIN_EN
        tbl[4] = mk("both",     1, 32'h200, 1, 0, 32'h44, 0,          1, 0, 0, 32'h200, 0,           0, 0, 0);
        tbl[5] = mk("dm_retry", 0, 0,      1, 0, 32'h44, 0,           0, 1, 0, 32'h44, 0,            1, 0, memval(32'h200));
        tbl[6] = mk("idle_rv",  0, 0,      0, 0, 0,     0,            0, 0, 0, 0,      0,            0, 1, memval(32'h44));
`else
        tbl[4] = mk("both",     1, 32'h200, 1, 0, 32'h44, 0,          0, 1, 0, 32'h44, 0,            0, 0, 0);
        tbl[5] = mk("if_retry", 1, 32'h200, 0, 0, 0,    0,            1, 0, 0, 32'h200, 0,           0, 1, memval(32'h44));
        tbl[6] = mk("idle_rv",  0, 0,      0, 0, 0,     0,            0, 0, 0, 0,      0,            1, 0, memval(32'h200));
`endif
        tbl[7] = mk("idle_end", 0, 0,      0, 0, 0,     0,            0, 0, 0, 0,      0,            0, 0, 0);

        // Reset held with both requesters active: everything must stay quiet.
        rst = 1'b1; rst3 = 1'b1;
        bus3.if_req_i = 0; bus3.if_addr_i = 0; bus3.dm_req_i = 0; bus3.dm_we_i = 0;
        bus3.dm_addr_i = 0; bus3.dm_wdata_i = 0;
        v = mk("reset", 1, 32'h300, 1, 0, 32'h30, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(v);
            checkOutput(v);
        end
        @(negedge clk);
        rst = 1'b0; rst3 = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        v = mk("first_gnt", 1, 32'h300, 1, 0, 32'h30, 0, 1, 0, 0, 32'h300, 0, 0, 0, 0);
        checkOutput(v);
        v = mk("first_rv", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, memval(32'h300));
`else
        v = mk("first_gnt", 1, 32'h300, 1, 0, 32'h30, 0, 0, 1, 0, 32'h30, 0, 0, 0, 0);
        checkOutput(v);
        v = mk("first_rv", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, memval(32'h30));
`endif
        applyStimulus(v);
        checkOutput(v);

        for (int i = 0; i < 8; i++) begin
            applyStimulus(tbl[i]);
            checkOutput(tbl[i]);
        end

`ifdef ARB_ROUND_ROBIN_EN
        // Fresh pointer after reset prefers fetch, then strict alternation.
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            v = mk("rr", 1, 32'h400, 1, 0, 32'h50, 0, 1'(i % 2 == 0), 1'(i % 2 == 1), 0,
                   (i % 2 == 0) ? 32'h400 : 32'h50, 0, 0, 0, 0);
            applyStimulus(v);
            #2;
            check($sformatf("rr[%0d].if_gnt", i), 32'(bus1.if_gnt_o), 32'(v.exp_if_gnt));
            check($sformatf("rr[%0d].dm_gnt", i), 32'(bus1.dm_gnt_o), 32'(v.exp_dm_gnt));
        end
`else
        // Data hogs the port; fetch is forced through every ninth cycle.
        for (int i = 0; i < 20; i++) begin
            v = mk("starve", 1, 32'h400, 1, 0, 32'h50, 0, 1'(i == 8 || i == 17),
                   1'(!(i == 8 || i == 17)), 0, (i == 8 || i == 17) ? 32'h400 : 32'h50,
                   0, 0, 0, 0);
            applyStimulus(v);
            #2;
            check($sformatf("starve[%0d].if_gnt", i), 32'(bus1.if_gnt_o), 32'(v.exp_if_gnt));
            check($sformatf("starve[%0d].dm_gnt", i), 32'(bus1.dm_gnt_o), 32'(v.exp_dm_gnt));
        end
`endif
        applyStimulus(tbl[0]);

        // MEM_LAT=3: single load returns exactly three cycles after its grant.
        drive3(1, 32'h60);
        #2 check("lat3.dm_gnt", 32'(bus3.dm_gnt_o), 32'd1);
        for (int i = 1; i <= 4; i++) begin
            drive3(0, 0);
            #2;
            check($sformatf("lat3[%0d].dm_rvalid", i), 32'(bus3.dm_rvalid_o), 32'(i == 3));
            check($sformatf("lat3[%0d].if_rvalid", i), 32'(bus3.if_rvalid_o), 32'd0);
            if (i == 3) check("lat3.dm_rdata", bus3.dm_rdata_o, memval(32'h60));
        end

        // Two loads in flight, then a one-cycle reset drops both responses.
        drive3(1, 32'h64);
        #2 check("flight0.dm_gnt", 32'(bus3.dm_gnt_o), 32'd1);
        drive3(1, 32'h68);
        #2 check("flight1.dm_gnt", 32'(bus3.dm_gnt_o), 32'd1);
        drive3(0, 0);
        rst3 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i == 1) rst3 = 1'b0;
            #2;
            check($sformatf("flush[%0d].rvalid", i),
                  32'({bus3.if_rvalid_o, bus3.dm_rvalid_o}), 32'd0);
            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
